// File: rtl/npc_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
package npc_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  // RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate extender type select
  localparam int EXT_TYPE_W = 3;
  localparam logic [EXT_TYPE_W-1:0] EXT_S    = 3'b000;
  localparam logic [EXT_TYPE_W-1:0] EXT_U    = 3'b001;
  localparam logic [EXT_TYPE_W-1:0] EXT_J    = 3'b010;
  localparam logic [EXT_TYPE_W-1:0] EXT_I    = 3'b011;
  localparam logic [EXT_TYPE_W-1:0] EXT_B    = 3'b100;
  localparam logic [EXT_TYPE_W-1:0] EXT_NONE = 3'b111;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

endpackage

// File: rtl/npc_inst_class.sv
// Combinational opcode classifier: extender select plus the few flags the
// sequencer needs to route an instruction through EXEC/MEM/WB.
module npc_inst_class
  import npc_ctrl_pkg::*;
(
  input  logic [31:0]           inst,
  output logic [EXT_TYPE_W-1:0] ext_type,
  output logic                  is_mem,
  output logic                  is_store,
  output logic                  writes_rd,
  output logic                  is_ebreak,
  output logic                  illegal
);

  logic rd_nz;
  assign rd_nz     = (inst[11:7] != 5'd0);
  assign is_ebreak = (inst == EBREAK);

  // Opcode decode; writes to x0 are suppressed here so WB only checks one flag
  always_comb begin
    ext_type  = EXT_NONE;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: begin
        ext_type  = EXT_U;
        writes_rd = rd_nz;
      end
      OP_JAL: begin
        ext_type  = EXT_J;
        writes_rd = rd_nz;
      end
      OP_JALR, OP_OPIMM, OP_SYSTEM: begin
        ext_type  = EXT_I;
        writes_rd = rd_nz;
      end
      OP_LOAD: begin
        ext_type  = EXT_I;
        is_mem    = 1'b1;
        writes_rd = rd_nz;
      end
      OP_BRANCH: begin
        ext_type = EXT_B;
      end
      OP_STORE: begin
        ext_type = EXT_S;
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_OP: begin
        ext_type  = EXT_NONE;
        writes_rd = rd_nz;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/npc_ctrl_fsm.sv
// NPC multi-cycle sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// All outputs are registered from the next-state decode.
// Optional build macro NPC_CTRL_TIMEOUT_EN adds a watchdog on IFU/LSU waits.
//
// state  | meaning
// RESET  | one idle cycle after reset
// FETCH  | ifu_req high, waiting for ifu_valid
// DECODE | classify latched instruction, register ext_type
// EXEC   | single execute cycle, route to MEM or WB
// MEM    | lsu_req high, waiting for lsu_done
// WB     | pc_we (and rf_we) strobe
// HALT   | absorbing, left only by rst
module npc_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int EXT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  input  logic             ifu_valid,
  input  logic [31:0]      ifu_inst,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_done,
  output logic [31:0]      inst_q,
  output logic [EXT_W-1:0] ext_type,
  output logic             pc_we,
  output logic             rf_we,
  output logic             halt,
  output logic             illegal
);

  state_t state, state_n;

  logic [31:0]           inst_n;
  logic [EXT_W-1:0]      ext_n;
  logic                  halt_n, illegal_n;
  logic                  ifu_req_n, lsu_req_n, lsu_we_n, pc_we_n, rf_we_n;
  logic [EXT_TYPE_W-1:0] cls_ext;
  logic                  cls_mem, cls_store, cls_wr, cls_ebreak, cls_illegal;
  logic                  timed_out;

  npc_inst_class u_class (
    .inst      (inst_q),
    .ext_type  (cls_ext),
    .is_mem    (cls_mem),
    .is_store  (cls_store),
    .writes_rd (cls_wr),
    .is_ebreak (cls_ebreak),
    .illegal   (cls_illegal)
  );

`ifdef NPC_CTRL_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  assign timed_out = ((state == FETCH) || (state == MEM)) &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYC));

  // Wait counter: cleared on any state change, counts cycles spent waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state_n != state) begin
      wait_cnt <= '0;
    end else if ((state == FETCH) || (state == MEM)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog the limit has no effect; waits are unbounded
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC > 0);
  assign timed_out      = 1'b0;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_n   = state;
    inst_n    = inst_q;
    ext_n     = ext_type;
    halt_n    = halt;
    illegal_n = illegal;
    unique case (state)
      RESET:  state_n = FETCH;
      FETCH: begin
        if (ifu_valid) begin
          state_n = DECODE;
          inst_n  = ifu_inst;
        end else if (timed_out) begin
          state_n   = HALT;
          illegal_n = 1'b1;
        end
      end
      DECODE: begin
        ext_n = EXT_W'(cls_ext);
        if (cls_ebreak) begin
          state_n = HALT;
          halt_n  = 1'b1;
        end else if (cls_illegal) begin
          state_n   = HALT;
          illegal_n = 1'b1;
        end else begin
          state_n = EXEC;
        end
      end
      EXEC:   state_n = cls_mem ? MEM : WB;
      MEM: begin
        if (lsu_done) begin
          state_n = WB;
        end else if (timed_out) begin
          state_n   = HALT;
          illegal_n = 1'b1;
        end
      end
      WB:     state_n = FETCH;
      HALT:   state_n = HALT;
      default: state_n = RESET;
    endcase

    ifu_req_n = (state_n == FETCH);
    lsu_req_n = (state_n == MEM);
    lsu_we_n  = (state_n == MEM) && cls_store;
    pc_we_n   = (state_n == WB);
    rf_we_n   = (state_n == WB) && cls_wr;
  end

  // State and registered outputs; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET;
      inst_q   <= '0;
      ext_type <= EXT_W'(EXT_NONE);
      ifu_req  <= 1'b0;
      lsu_req  <= 1'b0;
      lsu_we   <= 1'b0;
      pc_we    <= 1'b0;
      rf_we    <= 1'b0;
      halt     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_n;
      inst_q   <= inst_n;
      ext_type <= ext_n;
      ifu_req  <= ifu_req_n;
      lsu_req  <= lsu_req_n;
      lsu_we   <= lsu_we_n;
      pc_we    <= pc_we_n;
      rf_we    <= rf_we_n;
      halt     <= halt_n;
      illegal  <= illegal_n;
    end
  end

endmodule
